// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_pkg
// Description : Register map, CTRL field positions and bus helpers shared by
//               the 7-segment scan controller and its refresh timer.
// Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    localparam logic [2:0]  REG_DATA       = 3'h0;
    localparam logic [2:0]  REG_CTRL       = 3'h4;

    localparam int          CTRL_EN        = 0;
    localparam int          CTRL_BLANK_LSB = 8;
    localparam logic [31:0] CTRL_RST       = 32'h1;

    // Register select decoded from address bit 2 (0x0 -> DATA, 0x4 -> CTRL).
    typedef enum logic {
        SEL_DATA = 1'b0,
        SEL_CTRL = 1'b1
    } reg_sel_e;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage : sevenseg_pkg
`default_nettype wire

// File: rtl/sevenseg_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_refresh_timer
// Description : Slot counter and digit index for the display scan, exposing
//               next-state index and guard flag so outputs can be registered
//               in step with the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_refresh_timer
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int CNT_W       = 17,
    parameter int IDX_W       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] idx_nxt_o,
    output logic             slot_end_o,
    output logic             guard_nxt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_end;

    assign slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!run_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o       = idx_q;
    assign idx_nxt_o   = idx_d;
    assign slot_end_o  = slot_end;
    assign guard_nxt_o = (cnt_d < CNT_W'(GUARD));

endmodule : sevenseg_refresh_timer
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_ctrl
// Description : iomem-mapped 8-digit 7-segment scan controller with frame
//               shadowing, per-digit blanking and anode guard time.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int          NUM_DIGITS  = 8,
    parameter int          REFRESH_DIV = 100000,
    parameter int          GUARD       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iomem_valid,
    output logic                  iomem_ready,
    input  logic [3:0]            iomem_wstrb,
    input  logic [31:0]           iomem_addr,
    input  logic [31:0]           iomem_wdata,
    output logic [31:0]           iomem_rdata,
    output logic [3:0]            digit_nib,
    output logic [NUM_DIGITS-1:0] an_n
);

    localparam int CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLANK_BY = CTRL_BLANK_LSB / 8;

    logic [31:0]           data_q, data_d;
    logic                  en_q, en_d;
    logic [7:0]            blank_q, blank_d;
    logic [31:0]           shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
    logic                  pend_q, pend_d;
    logic [2:0]            pend_addr_q, pend_addr_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0]            nib_q, nib_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;

    logic                  hit, take, run, wrap;
    logic [31:0]           ctrl_rd;
    reg_sel_e              sel;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic                  slot_end, guard_nxt;

    assign hit  = iomem_valid && (iomem_addr[31:3] == BASE_ADDR[31:3]);
    // A held request is acknowledged once; only a dropped valid or a new offset re-arms it.
    assign take = hit && !(pend_q && (iomem_addr[2:0] == pend_addr_q));
    assign sel  = reg_sel_e'(iomem_addr[2]);

    always_comb begin
        ctrl_rd                           = '0;
        ctrl_rd[CTRL_EN]                  = en_q;
        ctrl_rd[CTRL_BLANK_LSB +: 8]      = blank_q;
    end

    always_comb begin
        data_d      = data_q;
        en_d        = en_q;
        blank_d     = blank_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        ready_d     = 1'b0;
        rdata_d     = '0;
        if (take) begin
            pend_d      = 1'b1;
            pend_addr_d = iomem_addr[2:0];
            ready_d     = 1'b1;
            if (iomem_wstrb == 4'h0) begin
                rdata_d = (sel == SEL_CTRL) ? ctrl_rd : data_q;
            end else if (sel == SEL_DATA) begin
                data_d = apply_wstrb(data_q, iomem_wdata, iomem_wstrb);
            end else begin
                if (iomem_wstrb[0]) en_d = iomem_wdata[CTRL_EN];
                if (iomem_wstrb[BLANK_BY]) blank_d = iomem_wdata[CTRL_BLANK_LSB +: 8];
            end
        end else if (!hit) begin
            pend_d = 1'b0;
        end
    end

    // Holding the counter one extra cycle on re-enable starts the scan cleanly at cnt=0.
    assign run  = en_q && en_d;
    assign wrap = run && slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

    sevenseg_refresh_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .run_i       (run),
        .idx_o       (idx),
        .idx_nxt_o   (idx_nxt),
        .slot_end_o  (slot_end),
        .guard_nxt_o (guard_nxt)
    );

    // While disabled the shadow follows the live registers, including this cycle's write.
    always_comb begin
        shadow_data_d  = shadow_data_q;
        shadow_blank_d = shadow_blank_q;
        if (!en_q) begin
            shadow_data_d  = data_d;
            shadow_blank_d = blank_d[NUM_DIGITS-1:0];
        end else if (wrap) begin
            shadow_data_d  = data_q;
            shadow_blank_d = blank_q[NUM_DIGITS-1:0];
        end
    end

    always_comb begin
        nib_d  = shadow_data_d[{idx_nxt, 2'b00} +: 4];
        an_n_d = '1;
        if (en_d && !guard_nxt && !shadow_blank_d[idx_nxt]) begin
            an_n_d[idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q         <= '0;
            en_q           <= CTRL_RST[CTRL_EN];
            blank_q        <= CTRL_RST[CTRL_BLANK_LSB +: 8];
            shadow_data_q  <= '0;
            shadow_blank_q <= '0;
            pend_q         <= 1'b0;
            pend_addr_q    <= '0;
            ready_q        <= 1'b0;
            rdata_q        <= '0;
            nib_q          <= '0;
            an_n_q         <= '1;
        end else begin
            data_q         <= data_d;
            en_q           <= en_d;
            blank_q        <= blank_d;
            shadow_data_q  <= shadow_data_d;
            shadow_blank_q <= shadow_blank_d;
            pend_q         <= pend_d;
            pend_addr_q    <= pend_addr_d;
            ready_q        <= ready_d;
            rdata_q        <= rdata_d;
            nib_q          <= nib_d;
            an_n_q         <= an_n_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign digit_nib   = nib_q;
    assign an_n        = an_n_q;

endmodule : sevenseg_scan_ctrl
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_scan_ctrl
// Description : Directed bench for sevenseg_scan_ctrl with REFRESH_DIV=8,
//               GUARD=2 (64-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_ctrl;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic [3:0]  digit_nib;
    logic [7:0]  an_n;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int pos    = 0;
    bit model_en = 1'b1;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (8),
        .REFRESH_DIV (8),
        .GUARD       (2),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .digit_nib   (digit_nib),
        .an_n        (an_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // pos is the bench's own notion of frame position: idx = pos/8, cnt = pos%8.
    task automatic tick();
        @(posedge clk);
        #1;
        if (model_en) pos = (pos + 1) % 64;
    endtask

    task automatic goto(input int target);
        for (int i = 0; i < 70 && pos != target; i++) tick();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        iomem_addr  = addr;
        iomem_wdata = data;
        iomem_wstrb = strb;
        iomem_valid = 1'b1;
        tick();
        check("wr_ready", 32'(iomem_ready), 32'h1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
        iomem_addr  = addr;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        tick();
        check("rd_ready", 32'(iomem_ready), 32'h1);
        check("rd_data", iomem_rdata, exp);
        iomem_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_an;

        // Reset and idle scan of digit 0
        tick();
        tick();
        reset = 1'b0;
        pos   = 0;
        check("rst_an", 32'(an_n), 32'hFF);
        check("rst_nib", 32'(digit_nib), 32'h0);
        check("rst_ready", 32'(iomem_ready), 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        tick();
        check("guard1_an", 32'(an_n), 32'hFF);
        tick();
        check("cnt2_an", 32'(an_n), 32'hFE);
        check("cnt2_nib", 32'(digit_nib), 32'h0);

        // Mid-frame DATA write: single ready, old digits kept until wrap
        goto(20);
        bus_write(BASE, 32'h8765_4321, 4'hF);
        tick();
        check("ready_pulse_drop", 32'(iomem_ready), 32'h0);
        check("old_an", 32'(an_n), 32'hFB);
        check("old_nib", 32'(digit_nib), 32'h0);
        for (int d = 0; d < 8; d++) begin
            goto(d * 8 + 2);
            exp_an    = 8'hFF;
            exp_an[d] = 1'b0;
            check("frame_nib", 32'(digit_nib), 32'(d + 1));
            check("frame_an", 32'(an_n), 32'(exp_an));
        end

        // DATA write coinciding with the frame wrap lands one frame later
        goto(63);
        bus_write(BASE, 32'h1234_5678, 4'hF);
        tick();
        goto(2);
        check("wrap_old_nib", 32'(digit_nib), 32'h1);
        check("wrap_old_an", 32'(an_n), 32'hFE);
        goto(10);
        goto(2);
        check("wrap_new_nib", 32'(digit_nib), 32'h8);

        // Byte-lane write
        bus_write(BASE, 32'h0000_AB00, 4'b0010);
        tick();
        bus_read(BASE, 32'h1234_AB78);
        tick();
        check("rd_ready_drop", 32'(iomem_ready), 32'h0);
        check("rdata_zero", iomem_rdata, 32'h0);

        // BLANK mask for digits 0 and 2
        bus_write(BASE + 32'h4, 32'h0000_0501, 4'hF);
        tick();
        bus_read(BASE + 32'h4, 32'h0000_0501);
        tick();
        goto(0);
        goto(2);
        check("blank_d0", 32'(an_n), 32'hFF);
        goto(10);
        check("lit_d1", 32'(an_n), 32'hFD);
        check("lit_d1_nib", 32'(digit_nib), 32'h7);
        goto(18);
        check("blank_d2", 32'(an_n), 32'hFF);
        goto(26);
        check("lit_d3", 32'(an_n), 32'hF7);

        // Disable during digit 5, then re-enable
        goto(43);
        check("d5_an", 32'(an_n), 32'hDF);
        check("d5_nib", 32'(digit_nib), 32'h3);
        bus_write(BASE + 32'h4, 32'h0, 4'hF);
        pos      = 0;
        model_en = 1'b0;
        check("dis_an", 32'(an_n), 32'hFF);
        check("dis_idx0_nib", 32'(digit_nib), 32'h8);
        tick();
        tick();
        tick();
        check("dis_hold_an", 32'(an_n), 32'hFF);
        bus_write(BASE, 32'hCAFE_F00D, 4'hF);
        check("dis_track_nib", 32'(digit_nib), 32'hD);
        tick();
        bus_write(BASE + 32'h4, 32'h1, 4'hF);
        pos      = 0;
        model_en = 1'b1;
        check("reen_an0", 32'(an_n), 32'hFF);
        tick();
        check("reen_an1", 32'(an_n), 32'hFF);
        tick();
        check("reen_an2", 32'(an_n), 32'hFE);
        check("reen_nib", 32'(digit_nib), 32'hD);

        // Held request: exactly one ready
        iomem_addr  = BASE;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        tick();
        check("hold_ready1", 32'(iomem_ready), 32'h1);
        check("hold_rdata", iomem_rdata, 32'hCAFE_F00D);
        tick();
        check("hold_ready2", 32'(iomem_ready), 32'h0);
        tick();
        check("hold_ready3", 32'(iomem_ready), 32'h0);
        iomem_valid = 1'b0;
        tick();

        // Out-of-range address: no ready, no write
        iomem_addr  = BASE + 32'h8;
        iomem_wdata = 32'h0;
        iomem_wstrb = 4'hF;
        iomem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("miss_ready", 32'(iomem_ready), 32'h0);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        tick();
        bus_read(BASE, 32'hCAFE_F00D);
        tick();

        // Reset during a hit
        iomem_addr  = BASE;
        iomem_wdata = 32'h5555_5555;
        iomem_wstrb = 4'hF;
        iomem_valid = 1'b1;
        reset       = 1'b1;
        tick();
        check("rst_txn_ready", 32'(iomem_ready), 32'h0);
        check("rst_txn_an", 32'(an_n), 32'hFF);
        reset       = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        tick();
        bus_read(BASE + 32'h4, 32'h1);
        tick();
        bus_read(BASE, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_sevenseg_scan_ctrl
`default_nettype wire
